// File: rtl/image_loader.sv
// image_loader: accepts a byte stream while the top level is in LOAD and
// scatters it into the binarized kernel weights followed by the binarized
// 28x28 input image. The contents are held stable for the consuming layers.
module image_loader #(
    parameter int WT_BYTES  = 9,
    parameter int PIX_BYTES = 98
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             state,
    input  logic [7:0]             data_in,
    input  logic                   data_valid,
    output logic                   data_ready,
    output logic [7:0][2:0][2:0]   weights,
    output logic [27:0][27:0]      pixels,
    output logic [6:0]             byte_cnt,
    output logic                   done
);

    localparam int         TOTAL     = WT_BYTES + PIX_BYTES;
    localparam logic [6:0] LAST_BYTE = 7'(TOTAL - 1);

    // Top-level state codes; anything outside IDLE/LOAD behaves as a layer state
    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_LOAD    = 3'b001,
        ST_LAYER_1 = 3'b010,
        ST_LAYER_2 = 3'b011,
        ST_LAYER_3 = 3'b100
    } top_state_t;

    // Flat bit-vectors: linear weight index w and pixel index p land exactly
    // on bit w / bit p of these, which matches the packed port layout.
    logic [8*WT_BYTES-1:0]  wt_flat;
    logic [8*PIX_BYTES-1:0] pix_flat;

    logic is_load;
    logic is_idle;
    logic accept;

    assign is_load    = (state == ST_LOAD);
    assign is_idle    = (state == ST_IDLE);
    assign data_ready = is_load && !done;
    assign accept     = data_valid && data_ready;

    assign weights = wt_flat;
    assign pixels  = pix_flat;

    // Byte counter and completion flag; IDLE clears them, layer states hold them
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
            done     <= 1'b0;
        end else if (is_idle) begin
            byte_cnt <= '0;
            done     <= 1'b0;
        end else if (accept && (byte_cnt <= LAST_BYTE)) begin
            byte_cnt <= byte_cnt + 7'd1;
            if (byte_cnt == LAST_BYTE) begin
                done <= 1'b1;
            end
        end
    end

    // Storage: the accepted byte is steered by byte_cnt alone into one weight or pixel slot
    always_ff @(posedge clk) begin
        if (rst) begin
            wt_flat  <= '0;
            pix_flat <= '0;
        end else if (accept) begin
            for (int k = 0; k < WT_BYTES; k++) begin
                if (byte_cnt == 7'(k)) begin
                    wt_flat[8*k +: 8] <= data_in;
                end
            end
            for (int k = 0; k < PIX_BYTES; k++) begin
                if (byte_cnt == 7'(WT_BYTES + k)) begin
                    pix_flat[8*k +: 8] <= data_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// tb_image_loader: self-checking bench for image_loader. A behavioural model
// keeps the expected kernel/image contents as kernel/row/col and row/col
// arrays filled from the byte index arithmetic, plus the expected counter.
module tb_image_loader;

    localparam logic [2:0] IDLE    = 3'b000;
    localparam logic [2:0] LOAD    = 3'b001;
    localparam logic [2:0] LAYER_1 = 3'b010;
    localparam int         TOTAL   = 107;

    logic                 clk;
    logic                 rst;
    logic [2:0]           state;
    logic [7:0]           data_in;
    logic                 data_valid;
    logic                 data_ready;
    logic [7:0][2:0][2:0] weights;
    logic [27:0][27:0]    pixels;
    logic [6:0]           byte_cnt;
    logic                 done;

    int checks = 0;
    int errors = 0;

    bit exp_w [8][3][3];
    bit exp_p [28][28];
    int m_cnt;
    bit m_done;

    typedef struct {
        logic       r;
        logic [2:0] st;
        logic       dv;
        logic [7:0] d;
        int         exp_cnt;
        logic       exp_done;
        logic       exp_ready;
    } vec_t;

    vec_t vecs [11];

    image_loader #(.WT_BYTES(9), .PIX_BYTES(98)) dut (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .weights    (weights),
        .pixels     (pixels),
        .byte_cnt   (byte_cnt),
        .done       (done)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelClear();
        foreach (exp_w[k, r, c]) exp_w[k][r][c] = 1'b0;
        foreach (exp_p[r, c]) exp_p[r][c] = 1'b0;
        m_cnt  = 0;
        m_done = 1'b0;
    endtask

    task automatic modelAccept(input int b, input logic [7:0] d);
        int w;
        int p;
        for (int i = 0; i < 8; i++) begin
            if (b < 9) begin
                w = 8 * b + i;
                exp_w[w / 9][(w % 9) / 3][w % 3] = d[i];
            end else begin
                p = 8 * (b - 9) + i;
                exp_p[p / 28][p % 28] = d[i];
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [2:0] st, input logic dv,
                                 input logic [7:0] d, output logic rdy_seen);
        logic exp_ready;
        logic acc;
        rst        = r;
        state      = st;
        data_valid = dv;
        data_in    = d;
        #1;
        exp_ready = (st == LOAD) && !m_done;
        rdy_seen  = data_ready;
        check("data_ready", int'(data_ready), int'(exp_ready));
        acc = !r && dv && exp_ready;
        @(posedge clk);
        #1;
        if (r) begin
            modelClear();
        end else if (st == IDLE) begin
            m_cnt  = 0;
            m_done = 1'b0;
        end else if (acc) begin
            modelAccept(m_cnt, d);
            m_cnt++;
            if (m_cnt == TOTAL) m_done = 1'b1;
        end
        check("byte_cnt", int'(byte_cnt), m_cnt);
        check("done", int'(done), int'(m_done));
    endtask

    task automatic checkOutput(input string name);
        int bad = 0;
        foreach (exp_w[k, r, c]) if (weights[k][r][c] !== exp_w[k][r][c]) bad++;
        foreach (exp_p[r, c]) if (pixels[r][c] !== exp_p[r][c]) bad++;
        check(name, bad, 0);
    endtask

    task automatic doReset();
        logic rdy;
        applyStimulus(1'b1, IDLE, 1'b0, 8'h00, rdy);
    endtask

    task automatic loadRandom(input int n);
        logic rdy;
        for (int b = 0; b < n; b++) applyStimulus(1'b0, LOAD, 1'b1, 8'($urandom), rdy);
    endtask

    // Test sequence: vector table first, then the multi-cycle scenarios
    initial begin
        logic rdy;
        logic [7:0] pix8;
        int cyc;

        rst = 1'b0; state = IDLE; data_valid = 1'b0; data_in = 8'h00;
        modelClear();

        vecs[0]  = '{1'b1, IDLE,    1'b0, 8'h00, 0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, LOAD,    1'b1, 8'hA5, 1, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, LOAD,    1'b0, 8'h00, 1, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, LOAD,    1'b1, 8'h3C, 2, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, LAYER_1, 1'b1, 8'hFF, 2, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 3'b101,  1'b1, 8'hFF, 2, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 3'b111,  1'b1, 8'hFF, 2, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, LOAD,    1'b1, 8'h0F, 3, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, IDLE,    1'b1, 8'hFF, 0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, LOAD,    1'b1, 8'h11, 1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, LOAD,    1'b1, 8'h22, 0, 1'b0, 1'b1};

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].r, vecs[i].st, vecs[i].dv, vecs[i].d, rdy);
            check($sformatf("vec%0d ready", i), int'(rdy), int'(vecs[i].exp_ready));
            check($sformatf("vec%0d cnt", i), int'(byte_cnt), vecs[i].exp_cnt);
            check($sformatf("vec%0d done", i), int'(done), int'(vecs[i].exp_done));
        end
        checkOutput("vec storage after reset");

        // Single weight bit set, full back-to-back load
        doReset();
        for (int b = 0; b < TOTAL; b++) begin
            applyStimulus(1'b0, LOAD, 1'b1, (b == 0) ? 8'h01 : 8'h00, rdy);
            if (b == TOTAL - 2) check("seq1 done before last", int'(done), 0);
        end
        check("seq1 cnt", int'(byte_cnt), 107);
        check("seq1 done", int'(done), 1);
        check("seq1 w000", int'(weights[0][0][0]), 1);
        check("seq1 other bits", $countones(weights) + $countones(pixels), 1);
        checkOutput("seq1 storage");

        // Extra bytes after completion are ignored, then IDLE clears the counter only
        for (int b = 0; b < 5; b++) applyStimulus(1'b0, LOAD, 1'b1, 8'hFF, rdy);
        check("post-done cnt", int'(byte_cnt), 107);
        checkOutput("post-done storage");
        applyStimulus(1'b0, IDLE, 1'b0, 8'h00, rdy);
        check("idle cnt", int'(byte_cnt), 0);
        check("idle done", int'(done), 0);
        check("idle w000 kept", int'(weights[0][0][0]), 1);
        checkOutput("idle storage");

        // First pixel byte all ones, last pixel byte MSB only
        doReset();
        for (int b = 0; b < TOTAL; b++) begin
            applyStimulus(1'b0, LOAD, 1'b1, (b == 9) ? 8'hFF : ((b == 106) ? 8'h80 : 8'h00), rdy);
        end
        for (int i = 0; i < 8; i++) pix8[i] = pixels[0][i];
        check("seq2 pixels row0 0..7", int'(pix8), 255);
        check("seq2 pixel 0,8", int'(pixels[0][8]), 0);
        check("seq2 pixel 27,27", int'(pixels[27][27]), 1);
        check("seq2 weights zero", $countones(weights), 0);
        checkOutput("seq2 storage");

        // Random valid pattern over a full load
        doReset();
        cyc = 0;
        while (!m_done && cyc < 3000) begin
            applyStimulus(1'b0, LOAD, 1'($urandom_range(0, 1)), 8'($urandom), rdy);
            cyc++;
        end
        if (cyc >= 3000) check("seq3 cycle budget", cyc, 0);
        check("seq3 cnt", int'(byte_cnt), 107);
        check("seq3 done", int'(done), 1);
        checkOutput("seq3 storage");

        // Pause in LAYER_1 mid-load, then resume
        doReset();
        loadRandom(50);
        check("seq4 cnt before pause", int'(byte_cnt), 50);
        for (int c = 0; c < 20; c++) applyStimulus(1'b0, LAYER_1, 1'b1, 8'($urandom), rdy);
        check("seq4 cnt during pause", int'(byte_cnt), 50);
        checkOutput("seq4 storage during pause");
        loadRandom(57);
        check("seq4 cnt", int'(byte_cnt), 107);
        check("seq4 done", int'(done), 1);
        checkOutput("seq4 storage");

        // Reset in the middle of a load, then a clean reload
        doReset();
        loadRandom(60);
        applyStimulus(1'b1, LOAD, 1'b1, 8'hAA, rdy);
        check("seq5 cnt", int'(byte_cnt), 0);
        check("seq5 done", int'(done), 0);
        check("seq5 weights zero", $countones(weights), 0);
        check("seq5 pixels zero", $countones(pixels), 0);
        loadRandom(TOTAL);
        check("seq5 reload cnt", int'(byte_cnt), 107);
        check("seq5 reload done", int'(done), 1);
        checkOutput("seq5 reload storage");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 The module SHALL have parameter WT_BYTES, default 9, the number of weight bytes per load (8 kernels x 9 bits = 72 bits).
REQ-002 The module SHALL have parameter PIX_BYTES, default 98, the number of pixel bytes per load (784 bits).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port state, input, 3 bits: top-level state (IDLE=000, LOAD=001, LAYER_1=010, LAYER_2=011, LAYER_3=100).
REQ-006 The module SHALL have port data_in, input, 8 bits: stream byte.
REQ-007 The module SHALL have port data_valid, input, 1 bit: data_in valid this cycle.
REQ-008 The module SHALL have port data_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-009 The module SHALL have port weights, output, [7:0][2:0][2:0] (72 bits): binarized kernels.
REQ-010 The module SHALL have port pixels, output, [27:0][27:0] (784 bits): binarized image.
REQ-011 The module SHALL have port byte_cnt, output, 7 bits: bytes accepted in the current load (0..107).
REQ-012 The module SHALL have port done, output, 1 bit: the full image and all weights have been stored.

Function
REQ-013 The module SHALL drive data_ready = (state==LOAD) && !done, combinationally from registers and the state input only, never from data_valid.
REQ-014 A byte SHALL be accepted on a rising edge where data_valid && data_ready; exactly one byte SHALL be accepted per such edge, and byte_cnt SHALL increment by 1.
REQ-015 Bytes 0..WT_BYTES-1 SHALL be weight bytes: bit i of weight byte k goes to linear weight index w=8k+i, with kernel=w/9, row=(w%9)/3, col=w%3.
REQ-016 Bytes WT_BYTES..WT_BYTES+PIX_BYTES-1 SHALL be pixel bytes: bit i of pixel byte k (k = byte_cnt-WT_BYTES) goes to linear pixel index p=8k+i, with pixels[p/28][p%28].
REQ-017 The written byte SHALL be visible on weights/pixels the cycle after acceptance (1-cycle latency); unwritten bits SHALL hold their prior values.
REQ-018 On acceptance of byte WT_BYTES+PIX_BYTES-1 (byte_cnt 106 -> 107), done SHALL assert on the same edge, and data_ready SHALL deassert next cycle.
REQ-019 While done=1 and state==LOAD, further data_valid SHALL be ignored; byte_cnt SHALL saturate at 107 and storage SHALL be unchanged.
REQ-020 In LAYER_1/2/3, data_ready SHALL be 0, byte_cnt/done/storage SHALL hold, and pixels/weights SHALL remain stable for the consuming layers.
REQ-021 In IDLE, byte_cnt and done SHALL clear to 0 on the next edge, while storage contents are retained.
REQ-022 If state leaves LOAD mid-transfer to a LAYER state, byte_cnt SHALL hold; on return to LOAD, loading SHALL resume at the held byte_cnt.
REQ-023 Illegal state codes (101-111) SHALL be treated as LAYER states (hold, data_ready=0).
REQ-024 Storage writes SHALL use only byte_cnt for addressing; no out-of-range index SHALL be written, so byte_cnt >= 107 writes nothing.

Reset
REQ-025 When rst=1 at a rising edge, byte_cnt, done, pixels and weights SHALL all become 0, and data_ready SHALL be 0 unless state==LOAD.
REQ-026 Reset SHALL take priority over a simultaneous accepted byte, and that byte SHALL be discarded.
REQ-027 Reset asserted mid-load SHALL restart the load at byte 0 once rst falls.

Verification
REQ-028 Reset, then state=LOAD, then stream 107 bytes back-to-back with byte0=8'h01 and all others 8'h00 -> weights[0][0][0]=1, all other bits 0, done=1 after the 107th edge, byte_cnt=107.
REQ-029 Stream a pixel byte at index 9 = 8'hFF, others 0 -> pixels[0][0..7]=1, all other pixels 0; the pixel at index 783 set via the last byte=8'h80 -> pixels[27][27]=1.
REQ-030 Toggle data_valid randomly (about 50%) during a full load -> storage equals a model of the accepted bytes, with exactly 107 acceptances and done asserting on the final acceptance.
REQ-031 Switch to LAYER_1 after 50 bytes, hold 20 cycles with data_valid=1, then return to LOAD -> byte_cnt stays 50 during the hold, data_ready=0, and the load completes with correct storage after 57 more bytes.
REQ-032 After done, drive 5 extra valid bytes -> no change to storage or byte_cnt; then go to IDLE -> done=0, byte_cnt=0, and storage is unchanged.
REQ-033 Assert rst at byte 60 with data_valid=1 -> all outputs 0, and a following load from byte 0 completes correctly.
